hazard_fwd_unit: RTL

- Decode-side hazard and forwarding controller for the 5-stage pipeline.
- Shadows the destination fields of the instructions in EX and MEM.
- Computes the 2-bit select codes for the two EX-stage operand 4:1 muxes one cycle early, and registers them into EX alongside the ID/EX register.
- Detects load-use and (when forwarding is disabled) all RAW hazards, and stalls PC/IF-ID while injecting bubbles into ID/EX.

---
 rtl/hazard_fwd_unit.sv | 137 +++++++++++++
 1 files changed

// File: rtl/hazard_fwd_unit.sv
// Decode-side hazard detection and EX operand-select generation for the 5-stage pipeline.
// Optional macro FWD_EN enables EX/MEM and MEM/WB forwarding; without it every RAW hazard stalls.
module hazard_fwd_unit #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_rs1_used,
  input  logic              id_rs2_used,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_regwrite,
  input  logic              id_memread,
  input  logic              id_a_alt,
  input  logic              id_b_alt,
  input  logic              ex_flush,
  output logic [1:0]        fwd_a_sel,
  output logic [1:0]        fwd_b_sel,
  output logic              pc_write_en,
  output logic              ifid_write_en,
  output logic              idex_bubble,
  output logic [CNT_W-1:0]  stall_count
);

  localparam logic [REG_AW-1:0] REG_X0  = {REG_AW{1'b0}};
  localparam logic [CNT_W-1:0]  CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]  CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // x0 is hardwired to zero, so it never produces a dependency.
  function automatic logic src_hit(input logic used, input logic [REG_AW-1:0] rs,
                                   input logic wr, input logic [REG_AW-1:0] rd);
    return used & wr & (rd != REG_X0) & (rd == rs);
  endfunction

`ifdef FWD_EN
  function automatic logic [1:0] sel_code(input logic alt, input logic hit_ex, input logic hit_mem);
    logic [1:0] code;
    if (alt) begin
      code = 2'b11;
    end else if (hit_ex) begin
      code = 2'b01;
    end else if (hit_mem) begin
      code = 2'b10;
    end else begin
      code = 2'b00;
    end
    return code;
  endfunction
`endif

  logic [REG_AW-1:0] ex_rd_q, ex_rd_d, mem_rd_q, mem_rd_d;
  logic              ex_rw_q, ex_rw_d, ex_mr_q, ex_mr_d, mem_rw_q, mem_rw_d;
  logic [1:0]        fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

  logic ex_wr_s, ex_hit_a_s, ex_hit_b_s, mem_hit_a_s, mem_hit_b_s;
  logic hazard_s, bubble_s, load_id_s;
  logic [1:0] sel_a_s, sel_b_s;

  // Hazard detection, operand selects and next-state for the shadow slots and counter.
  always_comb begin
`ifdef FWD_EN
    ex_wr_s = ex_rw_q;
`else
    ex_wr_s = ex_rw_q | ex_mr_q;
`endif
    ex_hit_a_s  = src_hit(id_rs1_used, id_rs1, ex_wr_s, ex_rd_q);
    ex_hit_b_s  = src_hit(id_rs2_used, id_rs2, ex_wr_s, ex_rd_q);
    mem_hit_a_s = src_hit(id_rs1_used, id_rs1, mem_rw_q, mem_rd_q);
    mem_hit_b_s = src_hit(id_rs2_used, id_rs2, mem_rw_q, mem_rd_q);

`ifdef FWD_EN
    // Only a load in EX cannot be forwarded in time; everything else is bypassed.
    hazard_s = id_valid & (src_hit(id_rs1_used, id_rs1, ex_mr_q, ex_rd_q) |
                           src_hit(id_rs2_used, id_rs2, ex_mr_q, ex_rd_q));
    sel_a_s  = sel_code(id_a_alt, ex_hit_a_s, mem_hit_a_s);
    sel_b_s  = sel_code(id_b_alt, ex_hit_b_s, mem_hit_b_s);
`else
    hazard_s = id_valid & (ex_hit_a_s | ex_hit_b_s | mem_hit_a_s | mem_hit_b_s);
    sel_a_s  = id_a_alt ? 2'b11 : 2'b00;
    sel_b_s  = id_b_alt ? 2'b11 : 2'b00;
`endif

    bubble_s  = hazard_s | ex_flush;
    load_id_s = id_valid & ~bubble_s;

    ex_rd_d  = load_id_s ? id_rd : REG_X0;
    ex_rw_d  = load_id_s & id_regwrite;
    ex_mr_d  = load_id_s & id_memread;
    mem_rd_d = ex_rd_q;
    mem_rw_d = ex_rw_q;

    fwd_a_d = bubble_s ? 2'b00 : sel_a_s;
    fwd_b_d = bubble_s ? 2'b00 : sel_b_s;

    if (hazard_s && !ex_flush && (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + CNT_ONE;
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  // Shadow slots, registered selects and stall counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_rd_q     <= REG_X0;
      ex_rw_q     <= 1'b0;
      ex_mr_q     <= 1'b0;
      mem_rd_q    <= REG_X0;
      mem_rw_q    <= 1'b0;
      fwd_a_q     <= 2'b00;
      fwd_b_q     <= 2'b00;
      stall_cnt_q <= {CNT_W{1'b0}};
    end else begin
      ex_rd_q     <= ex_rd_d;
      ex_rw_q     <= ex_rw_d;
      ex_mr_q     <= ex_mr_d;
      mem_rd_q    <= mem_rd_d;
      mem_rw_q    <= mem_rw_d;
      fwd_a_q     <= fwd_a_d;
      fwd_b_q     <= fwd_b_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign fwd_a_sel     = fwd_a_q;
  assign fwd_b_sel     = fwd_b_q;
  assign stall_count   = stall_cnt_q;
  assign idex_bubble   = bubble_s;
  // A flush redirects fetch, so it overrides any stall on PC and IF/ID.
  assign pc_write_en   = ~hazard_s | ex_flush;
  assign ifid_write_en = ~hazard_s | ex_flush;

endmodule
